// File: rtl/viterbi_pkg.sv
// Shared constants for the K=7 rate-1/2 code (octal 171/133), used by the
// encoder here and by the decoder's branch-metric logic.
package viterbi_pkg;

    localparam int K     = 7;
    localparam int MEM   = K - 1;
    localparam int SYM_W = 2;

    localparam logic [K-1:0] G0_POLY = 7'b1111001;
    localparam logic [K-1:0] G1_POLY = 7'b1011011;

    typedef enum logic {
        DATA = 1'b0,
        TAIL = 1'b1
    } enc_state_t;

endpackage

// File: rtl/conv_parity.sv
// Parity of one generator tap set over the encode window {u, sr}.
module conv_parity
    import viterbi_pkg::*;
#(
    parameter int W = K
) (
    input  logic [W-1:0] window_i,
    input  logic [W-1:0] poly_i,
    output logic         parity_o
);

    assign parity_o = ^(window_i & poly_i);

endmodule

// File: rtl/conv_encoder_k7.sv
// Rate-1/2, K=7 feedforward convolutional encoder with a single registered
// output stage and optional K-1 zero-bit trellis termination.
module conv_encoder_k7
    import viterbi_pkg::*;
#(
    parameter int           K       = viterbi_pkg::K,
    parameter logic [K-1:0] G0      = G0_POLY,
    parameter logic [K-1:0] G1      = G1_POLY,
    parameter bit           TAIL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_pair,
    output logic             out_last
);

    localparam int                CNT_W     = $clog2(K);
    localparam logic [CNT_W-1:0]  TAIL_LAST = CNT_W'(K - 2);

    enc_state_t       state_q, state_d;
    logic [K-2:0]     sr_q, sr_d;
    logic [CNT_W-1:0] tail_cnt_q, tail_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [SYM_W-1:0] out_pair_q, out_pair_d;
    logic             out_last_q, out_last_d;

    logic             load;
    logic             u;
    logic [K-1:0]     window;
    logic             par0, par1;

    // Tail bits are zeros, so the encoder input is forced low outside DATA.
    assign u      = (state_q == DATA) ? in_bit : 1'b0;
    assign window = {u, sr_q};

    conv_parity #(.W(K)) u_par0 (
        .window_i (window),
        .poly_i   (G0),
        .parity_o (par0)
    );

    conv_parity #(.W(K)) u_par1 (
        .window_i (window),
        .poly_i   (G1),
        .parity_o (par1)
    );

    always_comb begin
        load        = !out_valid_q || out_ready;
        in_ready    = (state_q == DATA) && load;
        state_d     = state_q;
        sr_d        = sr_q;
        tail_cnt_d  = tail_cnt_q;
        out_valid_d = out_valid_q;
        out_pair_d  = out_pair_q;
        out_last_d  = out_last_q;

        case (state_q)
            DATA: begin
                if (in_valid && load) begin
                    out_valid_d = 1'b1;
                    out_pair_d  = {par1, par0};
                    out_last_d  = 1'b0;
                    sr_d        = {u, sr_q[K-2:1]};
                    if (in_last) begin
                        if (TAIL_EN) begin
                            state_d    = TAIL;
                            tail_cnt_d = '0;
                        end else begin
                            out_last_d = 1'b1;
                            sr_d       = '0;
                        end
                    end
                end else if (load) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            TAIL: begin
                if (load) begin
                    out_valid_d = 1'b1;
                    out_pair_d  = {par1, par0};
                    out_last_d  = 1'b0;
                    sr_d        = {u, sr_q[K-2:1]};
                    tail_cnt_d  = tail_cnt_q + 1'b1;
                    // Final tail symbol: sr is already zero; clearing it again
                    // guards the next frame against any upset.
                    if (tail_cnt_q == TAIL_LAST) begin
                        out_last_d = 1'b1;
                        state_d    = DATA;
                        sr_d       = '0;
                        tail_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = DATA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DATA;
            sr_q        <= '0;
            tail_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_pair_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            tail_cnt_q  <= tail_cnt_d;
            out_valid_q <= out_valid_d;
            out_pair_q  <= out_pair_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pair  = out_pair_q;
    assign out_last  = out_last_q;

endmodule

// File: doc/conv_encoder_k7.md
Name: conv_encoder_k7

Overview:
Rate-1/2, constraint-length-7 feedforward convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder's branch-metric and ACS path, and produces the 2-bit symbol pairs the decoder consumes as rx_pair. It accepts one information bit per handshake and emits one registered symbol pair per handshake. At end of frame it optionally appends K-1 zero tail bits so the decoder's trellis terminates in state 0.

Parameters:
K, 7, constraint length; memory depth is K-1 = 6.
G0, 7'b1111001 (octal 171), generator polynomial for symbol bit 0.
G1, 7'b1011011 (octal 133), generator polynomial for symbol bit 1.
TAIL_EN, 1, 1 = append K-1 zero tail bits after in_last; 0 = no tail.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  in_bit/in_last are valid.
in_ready  output  1  encoder can accept an input bit this cycle.
in_bit  input  1  information bit.
in_last  input  1  marks the final information bit of a frame.
out_valid  output  1  out_pair holds a valid symbol.
out_ready  input  1  downstream accepts out_pair this cycle.
out_pair  output  2  [0] = G0 parity, [1] = G1 parity; bit order matches the decoder's rx_pair.
out_last  output  1  marks the final symbol of a frame (last tail symbol, or the last data symbol when TAIL_EN=0).

Behaviour:
- Reset values: sr = 0, state = DATA, tail_cnt = 0, out_valid = 0, out_pair = 2'b00, out_last = 0.
- Register conventions:
  - sr[5:0] is the shift register; sr[5] holds the newest past bit.
  - Encode window w[6:0] = {u, sr[5:0]}, where u is the current bit.
  - out_pair[0] = ^(w & G0); out_pair[1] = ^(w & G1).
  - On every accepted bit, sr <= {u, sr[5:1]}.
- Output stage is a single register. out_pair/out_valid/out_last are registered outputs.
- Output load condition: load = !out_valid || out_ready, i.e. the output register is empty or being drained in the same cycle.
- Back-to-back throughput: 1 symbol per clock when out_ready is held high.
- Latency: 1 clock from input acceptance to out_valid.
- out_pair and out_last must stay stable while out_valid && !out_ready.
- State DATA:
  - in_ready = load.
  - Accept when in_valid && in_ready: u = in_bit, encode, shift.
  - If in_last is set and TAIL_EN=1: go to TAIL with tail_cnt = 0; out_last = 0.
  - If in_last is set and TAIL_EN=0: out_last = 1, sr cleared to 0 on the same edge, stay in DATA.
- State TAIL:
  - in_ready = 0; input is ignored even if in_valid = 1.
  - When load is true: u = 0, encode, shift, tail_cnt++.
  - When tail_cnt reaches 5 (6th tail symbol): out_last = 1, then return to DATA.
  - sr is naturally 0 after the 6 tail shifts; it is also forced to 0 on exit as a guard.
- Boundary conditions:
  - Downstream stall in TAIL freezes tail_cnt and sr.
  - A frame with in_last on its first bit is legal: 1 data symbol + 6 tail symbols.
  - in_last = 1 with in_valid = 0 has no effect.
  - Next frame: in_ready may assert on the same clock that the final tail symbol is accepted downstream (load true).
- Reset mid-frame or mid-tail: the next edge returns everything to reset values; a pending out_valid is dropped and no out_last is emitted.
- No combinational path from in_valid to out_valid. in_ready depends combinationally only on state, out_valid and out_ready.

Decomposition:
- Shared package viterbi_pkg:
  - Constants K, MEM = K-1, G0_POLY, G1_POLY.
  - Symbol-pair width SYM_W = 2.
  - Enum enc_state_t {DATA, TAIL}.
  - The decoder's branch-metric expectations derive from the same G0_POLY/G1_POLY.
- One combinational sub-module, conv_parity (inputs: window, poly; output: parity bit), instantiated twice.
- The FSM, tail counter and output register remain in conv_encoder_k7.

Test Plan:
- Zero frame: rst 1 clk; 8 bits of 0, last on bit 8, out_ready = 1 -> 14 symbols, all 2'b00; out_last only on the 14th symbol; in_ready low for exactly 6 cycles.
- Impulse: single bit 1 with in_last -> symbols 11, 01, 11, 11, 00, 10, 11 (out_pair[1:0]); out_last on the 7th; sr = 0 afterwards.
- Backpressure: same impulse with out_ready toggling 1, 0, 0, 1, … -> identical symbol sequence; out_pair stable during stalls; no drop or duplicate; in_ready = 0 throughout TAIL.
- TAIL_EN=0: bits 1, 1 with last on the 2nd -> symbols 11, 10; out_last on the 2nd; next frame's bit 1 yields 11 (state cleared).
- Reset mid-tail: assert rst after the 3rd tail symbol -> out_valid = 0 next cycle, no out_last; a subsequent impulse frame reproduces the exact 7-symbol impulse response.
- Random 1000-bit frames against a reference model (171/133) with random out_ready -> bit-exact symbols; decoder loopback with the team's Viterbi decoder -> zero bit errors.
